// File: rtl/csr_pkg.sv
// Shared definitions for the CSR command issuer.
//
// Contents:
//   csr_op_e            Zicsr funct3 values, which double as the CSR command opcodes
//   CSR_RO_PREFIX       index[11:10] value that marks a read-only CSR
//   csr_is_read_only()  read-only predicate on a 12-bit CSR address
//   csr_issue_state_t   issuer FSM state type and its state constants
package csr_pkg;

  // Zicsr funct3 encodings. funct3 values 000 and 100 are not CSR accesses.
  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_e;

  // The top two address bits equal to 2'b11 mark a read-only CSR.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  function automatic logic csr_is_read_only(input logic [11:0] index);
    return index[11:10] == CSR_RO_PREFIX;
  endfunction

  // Issuer FSM states. They are plain constants so older tools can still use them.
  typedef logic [1:0] csr_issue_state_t;
  localparam csr_issue_state_t IDLE    = 2'd0;
  localparam csr_issue_state_t ISSUE   = 2'd1;
  localparam csr_issue_state_t RESP    = 2'd2;
  localparam csr_issue_state_t ILLEGAL = 2'd3;

endpackage

// File: rtl/csr_cmd_issuer_decode.sv
// Combinational decode of a Zicsr instruction into its CSR command attributes.
//
// Ports:
//   funct3_i   Zicsr funct3 field
//   rd_i       destination register index
//   rs1_idx_i  rs1 field (this is the uimm for the immediate forms)
//   index_i    CSR address
//   opcode_o   command opcode; 0 when funct3 is not a CSR access
//   ren_o      the CSR is read
//   wen_o      the CSR is written
//   illegal_o  bad funct3, or a write to a read-only CSR
module csr_access_decode
  import csr_pkg::*;
#(
  parameter int unsigned CSR_IDX_W = 12
) (
  input  logic [2:0]           funct3_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_idx_i,
  input  logic [CSR_IDX_W-1:0] index_i,
  output logic [2:0]           opcode_o,
  output logic                 ren_o,
  output logic                 wen_o,
  output logic                 illegal_o
);

  logic bad_funct3;
  logic read_only;

  assign read_only = index_i[CSR_IDX_W-1 -: 2] == CSR_RO_PREFIX;

  always_comb begin
    opcode_o   = 3'b000;
    ren_o      = 1'b0;
    wen_o      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3_i)
      // Writes always happen. The read is skipped when the old value would go to x0.
      CSRRW, CSRRWI: begin
        opcode_o = funct3_i;
        ren_o    = rd_i != 5'd0;
        wen_o    = 1'b1;
      end
      // Set and clear forms always read. A zero rs1 index or zero uimm means no write.
      CSRRS, CSRRC, CSRRSI, CSRRCI: begin
        opcode_o = funct3_i;
        ren_o    = 1'b1;
        wen_o    = rs1_idx_i != 5'd0;
      end
      default: bad_funct3 = 1'b1;
    endcase
    // A read of a read-only CSR is legal. Only an actual write to one is illegal.
    illegal_o = bad_funct3 | (wen_o & read_only);
  end

endmodule

// File: rtl/csr_cmd_issuer.sv
// Initiator side of the CSR command interface.
//
// Accepts one decoded Zicsr instruction at a time. For a legal instruction it
// strobes a single command to the CSR unit, captures the old CSR value that
// comes back in the same cycle, and hands that value to writeback (only when
// rd != 0). An illegal form raises a one-cycle illegal-instruction event and
// no command is issued. flush aborts whatever is in flight.
//
// Ports:
//   clk, nrst                 clock; synchronous active-low reset
//   req_*                     decode request (valid/ready) and the instruction fields
//   csr_cmd_*, csr_reg_val,
//   csr_uimm                  command to the CSR unit; all zero unless csr_cmd_valid
//   csr_val_in                old CSR value returned during the command cycle
//   wb_valid/ready, wb_rd,
//   wb_data                   result handshake towards writeback
//   flush                     pipeline flush; highest priority
//   illegal_valid, illegal_pc illegal-instruction event
module csr_cmd_issuer
  import csr_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CSR_IDX_W = 12
) (
  input  logic                 clk,
  input  logic                 nrst,
  // Request from decode
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  logic [CSR_IDX_W-1:0] req_csr_index,
  input  logic [4:0]           req_rs1_idx,
  input  logic [XLEN-1:0]      req_rs1_val,
  input  logic [4:0]           req_rd,
  input  logic [XLEN-1:0]      req_pc,
  // Command to the CSR unit
  output logic                 csr_cmd_valid,
  output logic [2:0]           csr_cmd_opcode,
  output logic [CSR_IDX_W-1:0] csr_cmd_index,
  output logic                 csr_cmd_ren,
  output logic                 csr_cmd_wen,
  output logic [XLEN-1:0]      csr_reg_val,
  output logic [4:0]           csr_uimm,
  input  logic [XLEN-1:0]      csr_val_in,
  // Writeback
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  // Control and exception events
  input  logic                 flush,
  output logic                 illegal_valid,
  output logic [XLEN-1:0]      illegal_pc
);

  csr_issue_state_t state_q, state_d;

  logic [2:0]           opcode_q, opcode_d;
  logic                 ren_q, ren_d;
  logic                 wen_q, wen_d;
  logic [CSR_IDX_W-1:0] index_q, index_d;
  logic [4:0]           rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0]      rs1_val_q, rs1_val_d;
  logic [4:0]           rd_q, rd_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      result_q, result_d;

  logic [2:0] dec_opcode;
  logic       dec_ren;
  logic       dec_wen;
  logic       dec_illegal;

  // The incoming fields are decoded so an illegal form can be sent straight to
  // ILLEGAL. The registered decode results then drive the command.
  csr_access_decode #(
    .CSR_IDX_W (CSR_IDX_W)
  ) u_decode (
    .funct3_i  (req_funct3),
    .rd_i      (req_rd),
    .rs1_idx_i (req_rs1_idx),
    .index_i   (req_csr_index),
    .opcode_o  (dec_opcode),
    .ren_o     (dec_ren),
    .wen_o     (dec_wen),
    .illegal_o (dec_illegal)
  );

  logic in_idle;
  logic accept;
  logic cmd_fire;
  logic wb_fire;
  logic ill_fire;

  // req_ready is held low during a flush so an ignored request never looks accepted.
  assign in_idle  = state_q == IDLE;
  assign accept   = in_idle & req_valid & ~flush;
  assign cmd_fire = (state_q == ISSUE) & ~flush;
  assign wb_fire  = (state_q == RESP) & ~flush;
  assign ill_fire = (state_q == ILLEGAL) & ~flush;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    index_d   = index_q;
    rs1_idx_d = rs1_idx_q;
    rs1_val_d = rs1_val_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    result_d  = result_q;

    if (accept) begin
      opcode_d  = dec_opcode;
      ren_d     = dec_ren;
      wen_d     = dec_wen;
      index_d   = req_csr_index;
      rs1_idx_d = req_rs1_idx;
      rs1_val_d = req_rs1_val;
      rd_d      = req_rd;
      pc_d      = req_pc;
    end

    // csr_val_in is valid only while the command strobe is high.
    if (cmd_fire) begin
      result_d = csr_val_in;
    end

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_d = dec_illegal ? ILLEGAL : ISSUE;
          end
        end
        ISSUE:   state_d = (rd_q == 5'd0) ? IDLE : RESP;
        // No accept happens in the handshake cycle. The next request waits in IDLE.
        RESP:    state_d = wb_ready ? IDLE : RESP;
        ILLEGAL: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      index_q   <= '0;
      rs1_idx_q <= '0;
      rs1_val_q <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      index_q   <= index_d;
      rs1_idx_q <= rs1_idx_d;
      rs1_val_q <= rs1_val_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      result_q  <= result_d;
    end
  end

  assign req_ready = in_idle & ~flush;

  // Each payload is gated by its own strobe, so the interfaces read as zero when idle.
  assign csr_cmd_valid  = cmd_fire;
  assign csr_cmd_opcode = cmd_fire ? opcode_q : 3'b000;
  assign csr_cmd_index  = cmd_fire ? index_q : '0;
  assign csr_cmd_ren    = cmd_fire & ren_q;
  assign csr_cmd_wen    = cmd_fire & wen_q;
  assign csr_reg_val    = cmd_fire ? rs1_val_q : '0;
  assign csr_uimm       = cmd_fire ? rs1_idx_q : 5'd0;

  assign wb_valid = wb_fire;
  assign wb_rd    = wb_fire ? rd_q : 5'd0;
  assign wb_data  = wb_fire ? result_q : '0;

  assign illegal_valid = ill_fire;
  assign illegal_pc    = ill_fire ? pc_q : '0;

endmodule

// File: tb/tb_csr_cmd_issuer.sv
// Directed bench for csr_cmd_issuer. Inputs change 2 time units after the
// rising edge and outputs are sampled 1 unit later, which keeps both away
// from the edge.
module tb_csr_cmd_issuer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_index;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rd;
  logic [31:0] req_pc;
  logic        csr_cmd_valid;
  logic [2:0]  csr_cmd_opcode;
  logic [11:0] csr_cmd_index;
  logic        csr_cmd_ren;
  logic        csr_cmd_wen;
  logic [31:0] csr_reg_val;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_val_in;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        illegal_valid;
  logic [31:0] illegal_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_cmd_issuer #(
    .XLEN      (32),
    .CSR_IDX_W (12)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct3     (req_funct3),
    .req_csr_index  (req_csr_index),
    .req_rs1_idx    (req_rs1_idx),
    .req_rs1_val    (req_rs1_val),
    .req_rd         (req_rd),
    .req_pc         (req_pc),
    .csr_cmd_valid  (csr_cmd_valid),
    .csr_cmd_opcode (csr_cmd_opcode),
    .csr_cmd_index  (csr_cmd_index),
    .csr_cmd_ren    (csr_cmd_ren),
    .csr_cmd_wen    (csr_cmd_wen),
    .csr_reg_val    (csr_reg_val),
    .csr_uimm       (csr_uimm),
    .csr_val_in     (csr_val_in),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .flush          (flush),
    .illegal_valid  (illegal_valid),
    .illegal_pc     (illegal_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 2 units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [11:0] idx, input logic [4:0] rs1,
                           input logic [31:0] val, input logic [4:0] rd, input logic [31:0] pc);
    req_valid     = 1'b1;
    req_funct3    = f3;
    req_csr_index = idx;
    req_rs1_idx   = rs1;
    req_rs1_val   = val;
    req_rd        = rd;
    req_pc        = pc;
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_csr_index = '0; req_rs1_idx = '0;
    req_rs1_val = '0; req_rd = '0; req_pc = '0; csr_val_in = '0; wb_ready = 1'b1;
    flush = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    settle();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_cmd_valid", {31'd0, csr_cmd_valid}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_valid}, 32'd0);
    chk("rst_cmd_index", {20'd0, csr_cmd_index}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    // CSRRW rd=5 to mtvec
    drive_req(3'b001, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'h200);
    csr_val_in = 32'h0;
    tick(); req_valid = 1'b0; settle();
    chk("rw_cmd_valid", {31'd0, csr_cmd_valid}, 32'd1);
    chk("rw_opcode", {29'd0, csr_cmd_opcode}, 32'd1);
    chk("rw_index", {20'd0, csr_cmd_index}, 32'h305);
    chk("rw_ren", {31'd0, csr_cmd_ren}, 32'd1);
    chk("rw_wen", {31'd0, csr_cmd_wen}, 32'd1);
    chk("rw_reg_val", csr_reg_val, 32'h8000_0100);
    chk("rw_req_ready", {31'd0, req_ready}, 32'd0);
    tick(); settle();
    chk("rw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("rw_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("rw_wb_data", wb_data, 32'h0);
    chk("rw_cmd_off", {31'd0, csr_cmd_valid}, 32'd0);
    tick(); settle();
    chk("rw_idle", {31'd0, req_ready}, 32'd1);
    chk("rw_wb_off", {31'd0, wb_valid}, 32'd0);

    // CSRRS rs1=x0 is a pure read
    drive_req(3'b010, 12'h301, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'h204);
    tick(); req_valid = 1'b0; csr_val_in = 32'h4000_0100; settle();
    chk("rs_opcode", {29'd0, csr_cmd_opcode}, 32'd2);
    chk("rs_ren", {31'd0, csr_cmd_ren}, 32'd1);
    chk("rs_wen", {31'd0, csr_cmd_wen}, 32'd0);
    tick(); csr_val_in = 32'h0; settle();
    chk("rs_wb_rd", {27'd0, wb_rd}, 32'd3);
    chk("rs_wb_data", wb_data, 32'h4000_0100);
    tick(); settle();

    // CSRRWI rd=0, uimm=7: no read and no writeback
    drive_req(3'b101, 12'h340, 5'd7, 32'h1111_2222, 5'd0, 32'h208);
    tick(); req_valid = 1'b0; settle();
    chk("rwi_valid", {31'd0, csr_cmd_valid}, 32'd1);
    chk("rwi_opcode", {29'd0, csr_cmd_opcode}, 32'd5);
    chk("rwi_ren", {31'd0, csr_cmd_ren}, 32'd0);
    chk("rwi_wen", {31'd0, csr_cmd_wen}, 32'd1);
    chk("rwi_uimm", {27'd0, csr_uimm}, 32'd7);
    chk("rwi_reg_val", csr_reg_val, 32'h1111_2222);
    tick(); settle();
    chk("rwi_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("rwi_ready", {31'd0, req_ready}, 32'd1);

    // CSRRW to mhartid (read-only) is illegal
    drive_req(3'b001, 12'hF14, 5'd2, 32'h5, 5'd1, 32'h100);
    tick(); req_valid = 1'b0; settle();
    chk("ro_cmd_valid", {31'd0, csr_cmd_valid}, 32'd0);
    chk("ro_illegal", {31'd0, illegal_valid}, 32'd1);
    chk("ro_pc", illegal_pc, 32'h100);
    tick(); settle();
    chk("ro_illegal_off", {31'd0, illegal_valid}, 32'd0);
    chk("ro_ready", {31'd0, req_ready}, 32'd1);

    // CSRRS x0 of mhartid only reads, so it is legal
    drive_req(3'b010, 12'hF14, 5'd0, 32'h0, 5'd0, 32'h104);
    tick(); req_valid = 1'b0; settle();
    chk("ro_read_cmd", {31'd0, csr_cmd_valid}, 32'd1);
    chk("ro_read_illegal", {31'd0, illegal_valid}, 32'd0);
    tick(); settle();

    // funct3=100 is illegal
    drive_req(3'b100, 12'h300, 5'd1, 32'h0, 5'd2, 32'h300);
    tick(); req_valid = 1'b0; settle();
    chk("f3_illegal", {31'd0, illegal_valid}, 32'd1);
    chk("f3_pc", illegal_pc, 32'h300);
    chk("f3_no_cmd", {31'd0, csr_cmd_valid}, 32'd0);
    tick(); settle();

    // CSRRC with writeback stalled for 3 cycles
    drive_req(3'b011, 12'h300, 5'd2, 32'h8, 5'd7, 32'h400);
    wb_ready = 1'b0;
    tick(); req_valid = 1'b0; csr_val_in = 32'h1234_5678; settle();
    chk("rc_wen", {31'd0, csr_cmd_wen}, 32'd1);
    tick(); csr_val_in = 32'hDEAD_BEEF; settle();
    for (int i = 0; i < 3; i++) begin
      chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("stall_wb_data", wb_data, 32'h1234_5678);
      if (i < 2) tick();
      settle();
    end
    // Handshake cycle with a new request waiting: it must not be accepted yet
    wb_ready = 1'b1;
    drive_req(3'b001, 12'h340, 5'd3, 32'hA5, 5'd0, 32'h404);
    settle();
    chk("hs_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("hs_req_ready", {31'd0, req_ready}, 32'd0);
    tick(); settle();
    chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_no_cmd", {31'd0, csr_cmd_valid}, 32'd0);
    tick(); req_valid = 1'b0; settle();
    chk("b2b_cmd", {31'd0, csr_cmd_valid}, 32'd1);
    chk("b2b_reg_val", csr_reg_val, 32'hA5);
    tick(); settle();

    // flush during ISSUE
    drive_req(3'b001, 12'h305, 5'd1, 32'h77, 5'd5, 32'h500);
    tick(); req_valid = 1'b0; flush = 1'b1; settle();
    chk("fl_cmd_valid", {31'd0, csr_cmd_valid}, 32'd0);
    chk("fl_cmd_index", {20'd0, csr_cmd_index}, 32'd0);
    tick(); flush = 1'b0; settle();
    chk("fl_ready", {31'd0, req_ready}, 32'd1);
    chk("fl_no_wb", {31'd0, wb_valid}, 32'd0);

    // flush in IDLE causes the request to be ignored
    drive_req(3'b001, 12'h305, 5'd1, 32'h77, 5'd5, 32'h504);
    flush = 1'b1;
    tick(); req_valid = 1'b0; flush = 1'b0; settle();
    chk("fl_idle_no_cmd", {31'd0, csr_cmd_valid}, 32'd0);
    chk("fl_idle_ready", {31'd0, req_ready}, 32'd1);

    // Reset during RESP
    drive_req(3'b001, 12'h305, 5'd1, 32'h99, 5'd4, 32'h600);
    tick(); req_valid = 1'b0; csr_val_in = 32'hCAFE_0000; settle();
    tick(); settle();
    chk("rr_wb_valid", {31'd0, wb_valid}, 32'd1);
    nrst = 1'b0; wb_ready = 1'b0;
    tick(); nrst = 1'b1; settle();
    chk("rr_wb_off", {31'd0, wb_valid}, 32'd0);
    chk("rr_ready", {31'd0, req_ready}, 32'd1);
    chk("rr_wb_data", wb_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_cmd_issuer.md
Name: csr_cmd_issuer

Overview:
- Initiator side of the CSR command interface: accepts one decoded Zicsr instruction per transaction from decode and builds the CSR command (opcode, index, ren, wen, operand) for csr_exception.
- Captures the old CSR value and returns it to writeback through a valid/ready handshake.
- Flags illegal Zicsr forms (bad funct3, write to read-only CSR) to the exception event publisher.
- Serialises CSR accesses: only one instruction is in flight at a time.

Parameters:
- XLEN, 32, data width (matches rv32ima_pkg word_t).
- CSR_IDX_W, 12, CSR address width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- req_valid  in  1  decoded CSR instruction present
- req_ready  out  1  block can accept
- req_funct3  in  3  Zicsr funct3
- req_csr_index  in  12  CSR address
- req_rs1_idx  in  5  rs1 field (also uimm)
- req_rs1_val  in  XLEN  rs1 register value
- req_rd  in  5  destination register
- req_pc  in  XLEN  instruction PC
- csr_cmd_valid  out  1  command strobe to CSR unit
- csr_cmd_opcode  out  3  CSRRW..CSRRCI (csr_pkg encoding)
- csr_cmd_index  out  12  CSR address
- csr_cmd_ren  out  1  read enable
- csr_cmd_wen  out  1  write enable
- csr_reg_val  out  XLEN  rs1 operand
- csr_uimm  out  5  immediate operand
- csr_val_in  in  XLEN  old CSR value returned (combinational, same cycle as strobe)
- wb_valid  out  1  result ready for writeback
- wb_ready  in  1  writeback accepts
- wb_rd  out  5  destination register
- wb_data  out  XLEN  old CSR value
- flush  in  1  pipeline flush / trap taken
- illegal_valid  out  1  illegal-instruction event, one-cycle pulse
- illegal_pc  out  XLEN  PC of the illegal instruction

Behaviour:
- Reset, applied at a clk edge with nrst=0: state IDLE. All outputs are 0, except req_ready=1.
- States:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields.
    - funct3 in {000,100}: go to ILLEGAL.
    - Otherwise, wen=1 and req_csr_index[11:10]==2'b11: go to ILLEGAL.
    - Otherwise: go to ISSUE.
  - ISSUE: csr_cmd_valid=1 for exactly one cycle with the latched fields. Latch csr_val_in into the result register.
    - rd==0: go to IDLE.
    - Otherwise: go to RESP.
  - RESP: wb_valid=1 with wb_rd and wb_data held stable until wb_ready=1. Go to IDLE on the handshake cycle.
  - ILLEGAL: illegal_valid=1 and illegal_pc=latched PC for one cycle, then go to IDLE. No CSR command is issued.
- ren/wen rules:
  - CSRRW/CSRRWI: ren=(rd!=0), wen=1.
  - CSRRS/CSRRC: ren=1, wen=(rs1_idx!=0).
  - CSRRSI/CSRRCI: ren=1, wen=(uimm!=0).
- uimm is the raw rs1_idx field. csr_reg_val drives the latched rs1 value for every opcode.
- req_ready=1 only in IDLE. Latency from accept to csr_cmd_valid is 1 cycle. Earliest wb_valid is 2 cycles after accept.
- Back-to-back operation: no new accept in the RESP handshake cycle. The next accept happens in IDLE the following cycle.
- flush has the highest priority:
  - In any state, flush=1 forces IDLE next cycle.
  - In the flush cycle, csr_cmd_valid, wb_valid and illegal_valid are forced to 0 and req_valid is ignored.
- Reset mid-transaction: behaves as reset; no partial command is emitted.
- csr_cmd_* fields are 0 whenever csr_cmd_valid=0.

Decomposition:
- csr_pkg holds:
  - the funct3-to-opcode enum (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111);
  - the read-only predicate constant (index[11:10]==2'b11);
  - the state enum csr_issue_state_t {IDLE, ISSUE, RESP, ILLEGAL}.
- One combinational sub-module, csr_access_decode, maps (funct3, rd, rs1_idx, index) to (opcode, ren, wen, illegal).

Test Plan:
- CSRRW, rd=5, index=0x305, rs1_val=0x8000_0100, csr_val_in=0x0 -> cycle 1: cmd_valid, ren=1, wen=1, reg_val=0x8000_0100; cycle 2: wb_valid, wb_rd=5, wb_data=0x0.
- CSRRS, rs1_idx=0, rd=3, index=0x301, csr_val_in=0x4000_0100 -> wen=0, ren=1; wb_data=0x4000_0100.
- CSRRWI, rd=0, uimm=7, index=0x340 -> ren=0, wen=1, csr_uimm=7; no wb_valid; req_ready=1 at cycle 2.
- CSRRW to 0xF14 (mhartid), pc=0x100 -> no cmd_valid; illegal_valid for 1 cycle with illegal_pc=0x100.
- funct3=100 -> illegal_valid. Separately, wb_ready=0 for 3 cycles in RESP -> wb_valid held with wb_data stable, then wb_ready=1 -> IDLE.
- flush asserted during ISSUE -> cmd_valid=0 that cycle and IDLE next. Separately, nrst=0 during RESP -> wb_valid=0 and req_ready=1 after the edge.
